// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD sequencer and any other client of the
// two's-complement ALU.
//   state_t      : sequencer FSM states (3-bit encoding)
//   FN_*         : ALU function-select encodings driven on alu_fn
package gcd_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHKA   = 3'd1,
        CHKB   = 3'd2,
        SUB_AB = 3'd3,
        SUB_BA = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [1:0] FN_A_SUB_B = 2'b00;
    localparam logic [1:0] FN_B_SUB_A = 2'b01;
    localparam logic [1:0] FN_PASS_A  = 2'b10;
    localparam logic [1:0] FN_PASS_B  = 2'b11;

endpackage

// File: rtl/gcd_seq.sv
// GCD sequencer: computes gcd(a_in, b_in) by repeated subtraction using an
// external combinational ALU that is wired to the alu_* ports.
//   clk, rst           : clock, synchronous active-high reset
//   start, a_in, b_in  : request and operands, accepted only in IDLE
//   busy, done, err    : status; done pulses for one cycle with result/err valid
//   result             : GCD, held until the next accepted start
//   alu_a, alu_b       : current A/B registers to the ALU
//   alu_fn             : ALU function select (see gcd_pkg FN_*)
//   alu_c, alu_z, alu_n: ALU result, zero flag and negative flag
module gcd_seq
    import gcd_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] result,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_fn,
    input  logic [W-1:0] alu_c,
    input  logic         alu_z,
    input  logic         alu_n
);

    state_t       state_q, state_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] result_q, result_d;
    logic         err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        err_d    = err_q;
        alu_fn   = FN_PASS_A;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // MSB must be clear so the N flag is a valid A<B compare.
                    if (a_in[W-1] || b_in[W-1]) begin
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = DONE;
                    end else begin
                        a_d     = a_in;
                        b_d     = b_in;
                        err_d   = 1'b0;
                        state_d = CHKA;
                    end
                end
            end

            CHKA: begin
                alu_fn = FN_PASS_A;
                // A == 0: gcd(0, B) = B, which also covers gcd(0, 0) = 0.
                if (alu_z) begin
                    result_d = b_q;
                    state_d  = DONE;
                end else begin
                    state_d = CHKB;
                end
            end

            CHKB: begin
                alu_fn = FN_PASS_B;
                if (alu_z) begin
                    result_d = a_q;
                    state_d  = DONE;
                end else begin
                    state_d = SUB_AB;
                end
            end

            SUB_AB: begin
                alu_fn = FN_A_SUB_B;
                if (alu_z) begin
                    result_d = a_q;
                    state_d  = DONE;
                end else if (alu_n) begin
                    state_d = SUB_BA;
                end else begin
                    a_d = alu_c;
                end
            end

            SUB_BA: begin
                // Entered only when A < B, so B - A is strictly positive.
                alu_fn  = FN_B_SUB_A;
                b_d     = alu_c;
                state_d = SUB_AB;
            end

            DONE: begin
                alu_fn  = FN_PASS_A;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        err    = err_q;
        result = result_q;
        alu_a  = a_q;
        alu_b  = b_q;
    end

endmodule

// File: tb/tb_gcd_seq.sv
// Bench for gcd_seq paired with a behavioural two's-complement ALU.
// Stimulus pushes expected completions into a scoreboard queue; a monitor
// pops and compares whenever done is presented.
module tb_gcd_seq;
    import gcd_pkg::*;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in, b_in;
    logic         busy, done, err;
    logic [W-1:0] result;
    logic [W-1:0] alu_a, alu_b, alu_c;
    logic [1:0]   alu_fn;
    logic         alu_z, alu_n;

    gcd_seq #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_fn (alu_fn),
        .alu_c  (alu_c),
        .alu_z  (alu_z),
        .alu_n  (alu_n)
    );

    // Reference ALU.
    always_comb begin
        case (alu_fn)
            2'b00:   alu_c = alu_a - alu_b;
            2'b01:   alu_c = alu_b - alu_a;
            2'b10:   alu_c = alu_a;
            default: alu_c = alu_b;
        endcase
        alu_z = (alu_c == '0);
        alu_n = alu_c[W-1];
    end

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int unsigned  cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [1:0]  fn_q[$];
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: compares alu_fn trace and every done against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && fn_q.size() > 0) check("alu_fn_seq", {30'd0, alu_fn}, {30'd0, fn_q.pop_front()});
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", {16'd0, result}, {16'd0, e.res});
                    check("err", {31'd0, err}, {31'd0, e.err});
                    check("done_cycle", cyc, e.cyc);
                    check("busy_at_done", {31'd0, busy}, 32'd1);
                end
            end
        end
    end

    // Issue a start at a negedge; cycle 0 is the cycle it is sampled in.
    task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic expect_done,
                      input logic [W-1:0] res, input logic e, input int unsigned lat);
        exp_t x;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        if (expect_done) begin
            x.res = res;
            x.err = e;
            x.cyc = cyc + lat;
            exp_q.push_back(x);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("done_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_fn", {30'd0, alu_fn}, 32'd2);
        rst = 1'b0;

        // Basic run with fn trace; a start pulse mid-run must be ignored.
        fn_q = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
        go(16'd48, 16'd18, 1'b1, 16'd6, 1'b0, 9);
        repeat (2) @(negedge clk);
        check("busy_mid_run", {31'd0, busy}, 32'd1);
        go(16'd2, 16'd4, 1'b0, 16'd0, 1'b0, 0);
        drain();
        // Back-to-back start in the first IDLE cycle after done.
        go(16'd2, 16'd4, 1'b1, 16'd2, 1'b0, 6);
        drain();

        go(16'd12, 16'd12, 1'b1, 16'd12, 1'b0, 4);
        drain();
        go(16'd0, 16'd35, 1'b1, 16'd35, 1'b0, 2);
        drain();
        go(16'd35, 16'd0, 1'b1, 16'd35, 1'b0, 3);
        drain();
        go(16'd0, 16'd0, 1'b1, 16'd0, 1'b0, 2);
        drain();

        // Range rejection, then a clean run clears err.
        go(16'h8001, 16'd5, 1'b1, 16'd0, 1'b1, 1);
        drain();
        check("err_held", {31'd0, err}, 32'd1);
        go(16'd21, 16'd14, 1'b1, 16'd7, 1'b0, 7);
        drain();
        go(16'd7, 16'h8000, 1'b1, 16'd0, 1'b1, 1);
        drain();

        // Reset in cycle 5 of a long run.
        go(16'd1000, 16'd3, 1'b0, 16'd0, 1'b0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_result", {16'd0, result}, 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
        check("midrst_fn", {30'd0, alu_fn}, 32'd2);
        rst = 1'b0;
        go(16'd9, 16'd6, 1'b1, 16'd3, 1'b0, 7);
        drain();
        repeat (2) @(negedge clk);
        check("result_held", {16'd0, result}, 32'd3);
        check("idle_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
